// File: rtl/sram_like_arb_if.sv
// SRAM-like request/addr_ok/data_ok channel bundle.
// Fields: req/wr/size/wstrb/addr/wdata travel master->slave; addr_ok/data_ok/rdata return slave->master.
// Modports: master drives requests, slave accepts them and returns strobes/data.
interface sram_like_arb_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arb.sv
// Purpose: merge inst and data SRAM-like masters onto one memory port, returning data in issue order.
// Latency: zero-cycle combinational on request (req->mem_req, mem_addr_ok->addr_ok) and return (mem_data_ok->data_ok).
// Backpressure: losing master sees addr_ok low; tag FIFO full (count==DEPTH, no pop this cycle) drops mem_req.
// Ports: clk, resetn (async active-low); inst_sram/data_sram (slave modports, from CPU);
//        mem (master modport, to the memory bridge).
// Build options: ARB_RR_EN selects round-robin between simultaneous requests (default fixed data>inst);
//        ARB_ASSERT_EN enables the simulation check that flags mem_data_ok with no outstanding tag.
module sram_like_arb #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            resetn,
  sram_like_arb_if.slave  inst_sram,
  sram_like_arb_if.slave  data_sram,
  sram_like_arb_if.master mem
);

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t      state;
  logic             lock_owner;
  logic [DEPTH-1:0] tag_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic grant;
  logic gnt_req;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic head_tag;

`ifdef ARB_RR_EN
  logic last_winner;
`endif

  // Grant selection: a pending (locked) handshake always keeps its owner.
  always_comb begin
    grant = OWN_INST;
    if (state == LOCKED) begin
      grant = lock_owner;
    end else if (data_sram.req && inst_sram.req) begin
`ifdef ARB_RR_EN
      grant = ~last_winner;
`else
      grant = OWN_DATA;
`endif
    end else if (data_sram.req) begin
      grant = OWN_DATA;
    end
  end

  assign gnt_req    = (grant == OWN_DATA) ? data_sram.req : inst_sram.req;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PTR_W+1)'(DEPTH));
  assign pop        = mem.data_ok & ~fifo_empty;
  assign head_tag   = tag_q[rd_ptr];

  // A same-cycle pop frees the head slot, so a full FIFO can still accept.
  assign mem.req   = gnt_req & ~(fifo_full & ~pop);
  assign mem.wr    = (grant == OWN_DATA) ? data_sram.wr    : inst_sram.wr;
  assign mem.size  = (grant == OWN_DATA) ? data_sram.size  : inst_sram.size;
  assign mem.wstrb = (grant == OWN_DATA) ? data_sram.wstrb : inst_sram.wstrb;
  assign mem.addr  = (grant == OWN_DATA) ? data_sram.addr  : inst_sram.addr;
  assign mem.wdata = (grant == OWN_DATA) ? data_sram.wdata : inst_sram.wdata;

  assign push = mem.req & mem.addr_ok;

  assign inst_sram.addr_ok = push & (grant == OWN_INST);
  assign data_sram.addr_ok = push & (grant == OWN_DATA);

  assign inst_sram.data_ok = pop & (head_tag == OWN_INST);
  assign data_sram.data_ok = pop & (head_tag == OWN_DATA);
  assign inst_sram.rdata   = mem.rdata;
  assign data_sram.rdata   = mem.rdata;

  // Lock FSM: holds the owner from the first unaccepted request cycle until addr_ok.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= UNLOCKED;
      lock_owner <= OWN_INST;
    end else begin
      case (state)
        UNLOCKED: begin
          if (mem.req && !mem.addr_ok) begin
            state      <= LOCKED;
            lock_owner <= grant;
          end
        end
        LOCKED: begin
          if (mem.addr_ok) state <= UNLOCKED;
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

  // In-order owner tag FIFO; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr] <= grant;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_winner <= OWN_INST;
    end else if (push) begin
      last_winner <= grant;
    end
  end
`endif

`ifdef ARB_ASSERT_EN
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(mem.data_ok && fifo_empty))
        else $error("mem_data_ok with no outstanding transaction");
    end
  end
`endif

endmodule

// File: tb/tb_sram_like_arb.sv
module tb_sram_like_arb;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sram_like_arb_if inst_if();
  sram_like_arb_if data_if();
  sram_like_arb_if mem_if();

  sram_like_arb #(.DEPTH(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .inst_sram (inst_if),
    .data_sram (data_if),
    .mem       (mem_if)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  // Drive both masters and the memory side for one cycle.
  task automatic drv(input logic ir, input logic [31:0] ia,
                     input logic dr, input logic [31:0] da,
                     input logic aok, input logic dok, input logic [31:0] rd);
    inst_if.req    = ir;
    inst_if.addr   = ia;
    inst_if.wr     = 1'b0;
    inst_if.size   = 2'd2;
    inst_if.wstrb  = 4'h0;
    inst_if.wdata  = 32'h0;
    data_if.req    = dr;
    data_if.addr   = da;
    data_if.wr     = 1'b0;
    data_if.size   = 2'd2;
    data_if.wstrb  = 4'h0;
    data_if.wdata  = 32'h0;
    mem_if.addr_ok = aok;
    mem_if.data_ok = dok;
    mem_if.rdata   = rd;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      nc();
      drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hdead0000 + 32'(i));
    end
    nc();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("drain_count", 32'(dut.count), 32'd0);
  endtask

  logic exp_dual [4];

  initial begin
    resetn = 1'b0;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) nc();
    resetn = 1'b1;
    #1;
    chk("rst_mem_req",   32'(mem_if.req),      32'd0);
    chk("rst_i_addr_ok", 32'(inst_if.addr_ok), 32'd0);
    chk("rst_d_addr_ok", 32'(data_if.addr_ok), 32'd0);
    chk("rst_i_data_ok", 32'(inst_if.data_ok), 32'd0);
    chk("rst_d_data_ok", 32'(data_if.data_ok), 32'd0);
    chk("rst_count",     32'(dut.count),       32'd0);

    // Single inst read.
    nc(); drv(1'b1, 32'h1c000000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); #1;
    chk("t1_mem_req",   32'(mem_if.req),      32'd1);
    chk("t1_mem_addr",  mem_if.addr,          32'h1c000000);
    chk("t1_i_addr_ok", 32'(inst_if.addr_ok), 32'd1);
    chk("t1_d_addr_ok", 32'(data_if.addr_ok), 32'd0);
    nc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    chk("t1_count",     32'(dut.count),       32'd1);
    chk("t1_idle_req",  32'(mem_if.req),      32'd0);
    nc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h02800000); #1;
    chk("t1_i_data_ok", 32'(inst_if.data_ok), 32'd1);
    chk("t1_i_rdata",   inst_if.rdata,        32'h02800000);
    chk("t1_d_data_ok", 32'(data_if.data_ok), 32'd0);

    // Simultaneous requests: data first, then inst; returns routed in that order.
    nc(); drv(1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0); #1;
    chk("t2_d_addr_ok", 32'(data_if.addr_ok), 32'd1);
    chk("t2_i_wait",    32'(inst_if.addr_ok), 32'd0);
    chk("t2_mem_addr0", mem_if.addr,          32'h100);
    nc(); drv(1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); #1;
    chk("t2_i_addr_ok", 32'(inst_if.addr_ok), 32'd1);
    chk("t2_mem_addr1", mem_if.addr,          32'h200);
    nc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h11); #1;
    chk("t2_ret0_d",    32'(data_if.data_ok), 32'd1);
    chk("t2_ret0_i",    32'(inst_if.data_ok), 32'd0);
    chk("t2_ret0_dat",  data_if.rdata,        32'h11);
    nc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h22); #1;
    chk("t2_ret1_i",    32'(inst_if.data_ok), 32'd1);
    chk("t2_ret1_d",    32'(data_if.data_ok), 32'd0);

    // Lock hold: data waits 3 cycles for addr_ok while inst also requests.
    nc(); drv(1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0); #1;
    chk("t3_addr_c0",   mem_if.addr,          32'h300);
    chk("t3_d_nok_c0",  32'(data_if.addr_ok), 32'd0);
    nc(); drv(1'b1, 32'h400, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0); #1;
    chk("t3_addr_c1",   mem_if.addr,          32'h300);
    chk("t3_i_nok_c1",  32'(inst_if.addr_ok), 32'd0);
    nc(); drv(1'b1, 32'h400, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0); #1;
    chk("t3_addr_c2",   mem_if.addr,          32'h300);
    nc(); drv(1'b1, 32'h400, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0); #1;
    chk("t3_d_addr_ok", 32'(data_if.addr_ok), 32'd1);
    chk("t3_i_nok_c3",  32'(inst_if.addr_ok), 32'd0);
    nc(); drv(1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); #1;
    chk("t3_i_addr_ok", 32'(inst_if.addr_ok), 32'd1);
    chk("t3_addr_c4",   mem_if.addr,          32'h400);
    drain(2);

    // Lock hold with inst as owner: data arriving later must not steal the bus.
    nc(); drv(1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    chk("t3b_addr_c0",  mem_if.addr,          32'h500);
    nc(); drv(1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0); #1;
    chk("t3b_addr_c1",  mem_if.addr,          32'h500);
    chk("t3b_d_nok",    32'(data_if.addr_ok), 32'd0);
    nc(); drv(1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0); #1;
    chk("t3b_i_ok",     32'(inst_if.addr_ok), 32'd1);
    chk("t3b_d_nok2",   32'(data_if.addr_ok), 32'd0);
    nc(); drv(1'b0, 32'h0, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0); #1;
    chk("t3b_d_ok",     32'(data_if.addr_ok), 32'd1);
    drain(2);

    // Full FIFO.
    for (int i = 0; i < 4; i++) begin
      nc(); drv(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); #1;
      chk($sformatf("t4_fill%0d", i), 32'(inst_if.addr_ok), 32'd1);
    end
    nc(); drv(1'b1, 32'h1010, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); #1;
    chk("t4_full_req",  32'(mem_if.req),      32'd0);
    chk("t4_full_aok",  32'(inst_if.addr_ok), 32'd0);
    chk("t4_full_cnt",  32'(dut.count),       32'd4);
    nc(); drv(1'b1, 32'h1010, 1'b0, 32'h0, 1'b1, 1'b1, 32'hab); #1;
    chk("t4_pp_req",    32'(mem_if.req),      32'd1);
    chk("t4_pp_aok",    32'(inst_if.addr_ok), 32'd1);
    chk("t4_pp_dok",    32'(inst_if.data_ok), 32'd1);
    nc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    chk("t4_pp_cnt",    32'(dut.count),       32'd4);
    drain(4);

    // Interleaved tags I, D, I.
    nc(); drv(1'b1, 32'h2000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    nc(); drv(1'b0, 32'h0, 1'b1, 32'h2004, 1'b1, 1'b0, 32'h0);
    nc(); drv(1'b1, 32'h2008, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    nc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA); #1;
    chk("t5_a_i",       32'(inst_if.data_ok), 32'd1);
    chk("t5_a_d",       32'(data_if.data_ok), 32'd0);
    chk("t5_a_dat",     inst_if.rdata,        32'hA);
    nc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB); #1;
    chk("t5_b_d",       32'(data_if.data_ok), 32'd1);
    chk("t5_b_i",       32'(inst_if.data_ok), 32'd0);
    chk("t5_b_dat",     data_if.rdata,        32'hB);
    nc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC); #1;
    chk("t5_c_i",       32'(inst_if.data_ok), 32'd1);
    chk("t5_c_d",       32'(data_if.data_ok), 32'd0);
    chk("t5_c_dat",     inst_if.rdata,        32'hC);

    // Reset mid-flight with two outstanding tags.
    nc(); drv(1'b1, 32'h3000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    nc(); drv(1'b0, 32'h0, 1'b1, 32'h3004, 1'b1, 1'b0, 32'h0);
    nc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    chk("t6_pre_cnt",   32'(dut.count),       32'd2);
    nc(); resetn = 1'b0; #1;
    chk("t6_async_cnt", 32'(dut.count),       32'd0);
    nc(); resetn = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h77); #1;
    chk("t6_stray_i",   32'(inst_if.data_ok), 32'd0);
    chk("t6_stray_d",   32'(data_if.data_ok), 32'd0);
    nc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    chk("t6_post_cnt",  32'(dut.count),       32'd0);

    // Continuous dual requests straight after reset.
`ifdef ARB_RR_EN
    exp_dual = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_dual = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      nc(); drv(1'b1, 32'h4000, 1'b1, 32'h4100, 1'b1, 1'b0, 32'h0); #1;
      chk($sformatf("t7_dual_d%0d", i), 32'(data_if.addr_ok), 32'(exp_dual[i]));
      chk($sformatf("t7_dual_i%0d", i), 32'(inst_if.addr_ok), 32'(!exp_dual[i]));
    end
    drain(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
